seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a DIGITS-digit common-cathode 7-segment display.
- One BCD-to-7-segment decoder is shared by all digits. The decoder has a 4-bit code input and 7-bit active-high segment outputs; code values above 9 produce its default pattern.
- Each cycle the block presents one digit's code to the decoder and drives that digit's active-low enable.
- Display data is double-buffered, so updates take effect only at a frame boundary.

Parameters:
- DIGITS, 4: number of digits scanned; must be at least 2.
- SCAN_DIV, 50000: clock cycles per digit slot.
- BLANK_CYC, 16: cycles at the start of each slot with all digits disabled (anti-ghosting); requires BLANK_CYC < SCAN_DIV.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  one-cycle strobe; capture data_in
- data_in  in  4*DIGITS  BCD digits; nibble k is digit k, with nibble 0 the least significant
- dc_code  out  4  code to the shared decoder's input
- dig_en_n  out  DIGITS  digit enables, active-low, at most one low
- frame  out  1  one-cycle pulse on each frame boundary
- update_ack  out  1  one-cycle pulse when the display buffer changes

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is asynchronous, active-low (rst_n).
  - All state is cleared on the falling edge of rst_n, whatever the clock is doing.
- Reset values:
  - cnt=0, idx=0, shadow=0, pending=0, pend_flag=0.
  - dig_en_n = all ones; dc_code = 0; frame = 0; update_ack = 0.
- Slot counter (cnt, 0..SCAN_DIV-1):
  - Increments every cycle.
  - At SCAN_DIV-1 it wraps to 0 and idx advances.
  - idx wraps from DIGITS-1 to 0.
- Frame boundary:
  - The cycle in which cnt==SCAN_DIV-1 and idx==DIGITS-1.
  - frame is high in the following cycle, exactly one cycle per frame.
- Outputs:
  - Registered, with no combinational path from inputs.
  - Each cycle they reflect the current cnt, idx and shadow.
  - When cnt < BLANK_CYC: dig_en_n is all ones, and dc_code still equals the new digit's nibble.
  - Otherwise: dig_en_n[idx]=0, all other bits are 1, and dc_code = shadow[4*idx+3 : 4*idx].
  - Nibbles above 9 pass through unchanged; the decoder handles them.
- Load path:
  - load, outside a boundary cycle: pending <= data_in and pend_flag <= 1. The shadow is not affected.
  - A second load within the same frame overwrites pending; the last load wins.
  - At a boundary with pend_flag=1: shadow <= pending, pend_flag <= 0, and update_ack pulses in the next cycle, coincident with frame.
  - At a boundary with pend_flag=0: shadow is unchanged and update_ack stays 0.
  - load in the boundary cycle itself: shadow <= data_in directly (it takes precedence over any pending value), pend_flag <= 0, and update_ack pulses.
- Reset mid-frame:
  - Everything returns to reset values immediately.
  - pending data is discarded.
  - Scanning restarts at digit 0, slot start, with the blank interval.
- Ordering:
  - Digits are scanned 0,1,...,DIGITS-1, then the sequence repeats.
  - A full frame lasts DIGITS*SCAN_DIV cycles.

Optional Feature:
- Macro: SEG_SCAN_LZ_BLANK_EN (leading-zero blanking).
- Defined:
  - Digit k>0 is suppressed when it and every more-significant nibble of shadow are zero.
  - During a suppressed digit's slot, dig_en_n stays all ones for the whole slot.
  - Digit 0 is never suppressed.
  - Slot timing, idx sequencing and dc_code are unchanged.
- Undefined: every digit is enabled in its slot after the blank interval.

Test Plan (DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, frame = 32 cycles):
1. Reset: hold rst_n=0, then release -> dig_en_n=4'b1111 and dc_code=0 through cnt=0..1; dig_en_n=4'b1110 from cnt=2; frame pulses first at cycle 32.
2. load with data_in=16'h1234 at cycle 5 -> shadow unchanged (dc_code=0) until boundary; update_ack and frame high at cycle 32. Next frame, per slot, dc_code/dig_en_n = 4/1110, 3/1101, 2/1011, 1/0111, with dig_en_n=1111 for 2 cycles at each slot start.
3. Two loads in one frame, 16'h1111 then 16'h9876 -> only 9876 is displayed after the boundary; exactly one update_ack.
4. load with 16'hABCD in the boundary cycle while 16'h5555 is pending -> shadow=ABCD; update_ack pulses; pend_flag=0; 5555 is never shown.
5. Assert rst_n low mid-slot on digit 2 with data pending -> outputs go to reset values immediately (asynchronously). After release: shadow=0, no update_ack at the next boundary, and the scan restarts at digit 0.
6. With SEG_SCAN_LZ_BLANK_EN defined, display 16'h0045 -> digits 3 and 2 stay dark for their whole slots. Display 16'h0000 -> only digit 0 is lit. Display 16'h0405 -> all digits are lit except digit 3.

Source files
------------

// File: rtl/seg_scan_if.sv
// Display-side bundle for the 7-segment scan controller: load strobe/data in,
// shared-decoder code plus digit enables and status pulses out.
interface seg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [3:0]            dc_code;
  logic [DIGITS-1:0]     dig_en_n;
  logic                  frame;
  logic                  update_ack;

  modport master (
    output load, data_in,
    input  dc_code, dig_en_n, frame, update_ack
  );

  modport slave (
    input  load, data_in,
    output dc_code, dig_en_n, frame, update_ack
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-cathode 7-segment scan controller with a double-buffered
// display register. Optional leading-zero blanking: define SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam int DW    = 4 * DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  if (DIGITS < 2) begin : g_bad_digits
    $error("seg_scan_ctrl: DIGITS must be at least 2");
  end
  if (BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
    $error("seg_scan_ctrl: BLANK_CYC must be less than SCAN_DIV");
  end

  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic [DW-1:0]     shadow, shadow_nx;
  logic [DW-1:0]     pending;
  logic              pend_flag;
  logic              slot_end, boundary, upd_nx, in_window;
  logic [3:0]        nib_nx;
  logic [DIGITS-1:0] en_nx;
  logic [DIGITS-1:0] sup;
  logic [3:0]        dc_code_q;
  logic [DIGITS-1:0] dig_en_n_q;
  logic              frame_q, update_ack_q;
  logic              load;
  logic [DW-1:0]     data_in;
`ifdef SEG_SCAN_LZ_BLANK_EN
  logic              zero_run;
`endif

  assign load    = bus.load;
  assign data_in = bus.data_in;

  // Outputs are computed from next-state values so the registered outputs
  // line up with the cnt/idx/shadow registers in the same cycle.
  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    boundary  = slot_end && (idx == IDX_LAST);
    cnt_nx    = slot_end ? '0 : cnt + CNT_W'(1);
    idx_nx    = idx;
    if (slot_end) begin
      idx_nx = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end

    shadow_nx = shadow;
    upd_nx    = 1'b0;
    if (boundary) begin
      if (load) begin
        shadow_nx = data_in;
        upd_nx    = 1'b1;
      end else if (pend_flag) begin
        shadow_nx = pending;
        upd_nx    = 1'b1;
      end
    end

    sup = '0;
`ifdef SEG_SCAN_LZ_BLANK_EN
    // A digit is dark only while it and everything above it is zero.
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (shadow_nx[4*k +: 4] == 4'd0);
      sup[k]   = zero_run;
    end
`endif

    in_window = (cnt_nx >= BLANK_END);
    nib_nx    = 4'd0;
    en_nx     = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_nx == IDX_W'(k)) begin
        nib_nx   = shadow_nx[4*k +: 4];
        en_nx[k] = !(in_window && !sup[k]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= '0;
      shadow       <= '0;
      pending      <= '0;
      pend_flag    <= 1'b0;
      dc_code_q    <= 4'd0;
      dig_en_n_q   <= '1;
      frame_q      <= 1'b0;
      update_ack_q <= 1'b0;
    end else begin
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      shadow <= shadow_nx;
      if (load && !boundary) begin
        pending   <= data_in;
        pend_flag <= 1'b1;
      end else if (boundary) begin
        pend_flag <= 1'b0;
      end
      dc_code_q    <= nib_nx;
      dig_en_n_q   <= en_nx;
      frame_q      <= boundary;
      update_ack_q <= upd_nx;
    end
  end

  assign bus.dc_code    = dc_code_q;
  assign bus.dig_en_n   = dig_en_n_q;
  assign bus.frame      = frame_q;
  assign bus.update_ack = update_ack_q;

endmodule
